// File: rtl/dmem_arbiter_if.sv
// Data-memory requester port: request fields in, grant and
// one-cycle response back out.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, size, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, size, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Core/DMA data-memory arbiter with bounded DMA starvation and
// fixed one-cycle response latency for every granted access.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  dmem_arbiter_if.slave c,
  dmem_arbiter_if.slave d,
  output logic         mem_en,
  output logic         mem_we,
  output logic [1:0]   mem_size,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic [3:0]  starve_nxt;
  logic        both;
  logic        dma_win;
  logic        c_gnt;
  logic        d_gnt;
  logic        any_gnt;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_legal;

  logic        resp_valid;
  logic        resp_owner;
  logic        resp_read;
  logic        resp_err;

  function automatic logic legal_f(
    input logic [1:0] s,
    input logic [1:0] a
  );
    logic ok;
    case (s)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~a[0];
      2'b11:   ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign both    = c.req & d.req;
  assign dma_win = both & (starve_cnt == LIMIT);
  assign c_gnt   = ~rst & c.req & ~dma_win;
  assign d_gnt   = ~rst & d.req & (~c.req | dma_win);
  assign any_gnt = c_gnt | d_gnt;

  assign c.gnt = c_gnt;
  assign d.gnt = d_gnt;

  always_comb begin
    sel_we    = 1'b0;
    sel_size  = 2'b00;
    sel_addr  = '0;
    sel_wdata = '0;
    unique case (1'b1)
      c_gnt: begin
        sel_we    = c.we;
        sel_size  = c.size;
        sel_addr  = c.addr;
        sel_wdata = c.wdata;
      end
      d_gnt: begin
        sel_we    = d.we;
        sel_size  = d.size;
        sel_addr  = d.addr;
        sel_wdata = d.wdata;
      end
      default: ;
    endcase
  end

  assign sel_legal = legal_f(sel_size, sel_addr[1:0]);

  // Illegal accesses are consumed but never reach memory.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_size  = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    if (any_gnt && sel_legal) begin
      mem_en    = 1'b1;
      mem_we    = sel_we;
      mem_size  = sel_size;
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (d_gnt || !d.req) begin
      starve_nxt = '0;
    end else if (both && c_gnt) begin
      if (starve_cnt < LIMIT) starve_nxt = starve_cnt + 4'd1;
      else                    starve_nxt = LIMIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_cnt <= '0;
    else     starve_cnt <= starve_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
      resp_read  <= 1'b0;
      resp_err   <= 1'b0;
    end else if (any_gnt) begin
      resp_valid <= 1'b1;
      resp_owner <= d_gnt;
      resp_read  <= sel_legal & ~sel_we;
      resp_err   <= ~sel_legal;
    end else begin
      resp_valid <= 1'b0;
    end
  end

  // Gating by rst drops a response whose grant preceded reset.
  logic c_own;
  logic d_own;

  assign c_own = ~rst & resp_valid & ~resp_owner;
  assign d_own = ~rst & resp_valid & resp_owner;

  assign c.rvalid = c_own;
  assign c.err    = c_own & resp_err;
  assign c.rdata  = (c_own && resp_read) ? mem_rdata : '0;

  assign d.rvalid = d_own;
  assign d.err    = d_own & resp_err;
  assign d.rdata  = (d_own && resp_read) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed checks of dmem_arbiter against a
// behavioural arbitration and memory model.
module tb_dmem_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  dmem_arbiter_if cif ();
  dmem_arbiter_if dif ();

  dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .c         (cif.slave),
    .d         (dif.slave),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory device behind the arbiter, separate from the model's copy.
  logic [7:0] dev [1024];
  logic [7:0] ref_mem [1024];

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int i = 0; i < nbytes(mem_size); i++)
        dev[(mem_addr + i) & 32'h3ff] <= mem_wdata[8*i +: 8];
      mem_rdata <= 32'hA5A5A5A5;
    end else if (mem_en) begin
      logic [31:0] v;
      v = 32'h0;
      for (int i = 0; i < nbytes(mem_size); i++)
        v[8*i +: 8] = dev[(mem_addr + i) & 32'h3ff];
      mem_rdata <= v;
    end else begin
      mem_rdata <= 32'hA5A5A5A5;
    end
  end

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference state: core-win streak while DMA waits, pending response.
  int          streak = 0;
  bit          p_v = 0;
  int          p_own = 0;
  bit          p_err = 0;
  logic [31:0] p_rdata = 0;

  function automatic bit is_legal(input logic [1:0] s,
                                  input logic [31:0] a);
    if (s == 2'b00) return 1;
    if (s == 2'b01) return (a % 2) == 0;
    if (s == 2'b11) return (a % 4) == 0;
    return 0;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a,
                                           input logic [1:0] s);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < nbytes(s); i++)
      v[8*i +: 8] = ref_mem[(a + i) & 32'h3ff];
    return v;
  endfunction

  task automatic set_c(input bit q, input bit w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] wd);
    cif.req = q; cif.we = w; cif.size = s;
    cif.addr = a; cif.wdata = wd;
  endtask

  task automatic set_d(input bit q, input bit w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] wd);
    dif.req = q; dif.we = w; dif.size = s;
    dif.addr = a; dif.wdata = wd;
  endtask

  // One cycle: called at negedge with inputs already driven.
  task automatic step(input bit r, output int win);
    bit          cq, dq, lg, sw;
    logic [1:0]  ss;
    logic [31:0] sa, sd;
    bit          ev;
    rst = r;
    #1;
    cq = cif.req; dq = dif.req;
    if (r)            win = 0;
    else if (cq && dq) win = (streak == LIM) ? 2 : 1;
    else if (cq)      win = 1;
    else if (dq)      win = 2;
    else              win = 0;
    sw = (win == 1) ? cif.we   : dif.we;
    ss = (win == 1) ? cif.size : dif.size;
    sa = (win == 1) ? cif.addr : dif.addr;
    sd = (win == 1) ? cif.wdata : dif.wdata;
    lg = is_legal(ss, sa);
    chk("c_gnt", 32'(cif.gnt), 32'(win == 1));
    chk("d_gnt", 32'(dif.gnt), 32'(win == 2));
    chk("mem_en", 32'(mem_en), 32'(win != 0 && lg));
    chk("mem_we", 32'(mem_we), 32'(win != 0 && lg && sw));
    if (win == 0) begin
      chk("idle_size", 32'(mem_size), 0);
      chk("idle_addr", mem_addr, 0);
      chk("idle_wdata", mem_wdata, 0);
    end else if (lg) begin
      chk("mem_size", 32'(mem_size), 32'(ss));
      chk("mem_addr", mem_addr, sa);
      chk("mem_wdata", mem_wdata, sd);
    end
    ev = p_v && !r;
    chk("c_rvalid", 32'(cif.rvalid), 32'(ev && p_own == 1));
    chk("d_rvalid", 32'(dif.rvalid), 32'(ev && p_own == 2));
    chk("c_err", 32'(cif.err), 32'(ev && p_own == 1 && p_err));
    chk("d_err", 32'(dif.err), 32'(ev && p_own == 2 && p_err));
    chk("c_rdata", cif.rdata, (ev && p_own == 1) ? p_rdata : 0);
    chk("d_rdata", dif.rdata, (ev && p_own == 2) ? p_rdata : 0);
    @(posedge clk);
    if (r) begin
      streak = 0;
      p_v = 0;
    end else begin
      if (win == 2 || !dq)          streak = 0;
      else if (win == 1 && dq)      streak = (streak < LIM) ? streak + 1 : LIM;
      p_v = (win != 0);
      if (win != 0) begin
        p_own   = win;
        p_err   = !lg;
        p_rdata = (lg && !sw) ? ref_read(sa, ss) : 0;
        if (lg && sw)
          for (int i = 0; i < nbytes(ss); i++)
            ref_mem[(sa + i) & 32'h3ff] = sd[8*i +: 8];
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_c();
    set_c(($urandom % 4) != 0, 1'($urandom % 2), 2'($urandom % 4),
          $urandom % 64, $urandom);
  endtask

  task automatic rand_d();
    set_d(($urandom % 4) != 0, 1'($urandom % 2), 2'($urandom % 4),
          $urandom % 64, $urandom);
  endtask

  int w;
  int exp_seq [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dev[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    set_c(1, 1, 2'b11, 32'h40, 32'h1);
    set_d(1, 1, 2'b11, 32'h44, 32'h2);
    @(negedge clk);
    step(1, w);
    step(1, w);

    // Store then load the same word from the core.
    set_d(0, 0, 2'b00, 0, 0);
    set_c(1, 1, 2'b11, 32'h100, 32'hDEADBEEF);
    step(0, w);
    chk("sw_gnt", 32'(w), 1);
    set_c(1, 0, 2'b11, 32'h100, 0);
    step(0, w);
    chk("lw_rvalid", 32'(cif.rvalid), 1);
    chk("lw_rdata", cif.rdata, 32'hDEADBEEF);
    chk("lw_err", 32'(cif.err), 0);
    set_c(0, 0, 2'b00, 0, 0);
    step(0, w);

    // Both requesting continuously.
    set_d(1, 1, 2'b11, 32'h20, 32'h11);
    for (int i = 0; i < 10; i++) begin
      set_c(1, 0, 2'b11, 32'(4 * i), 0);
      step(0, w);
      chk("starve_seq", 32'(w), 32'(exp_seq[i]));
      if (w == 2) set_d(1, 1, 2'b11, 32'h24 + 32'(4 * i), 32'(i));
    end
    set_c(0, 0, 2'b00, 0, 0);
    set_d(0, 0, 2'b00, 0, 0);
    step(0, w);

    // Misaligned DMA halfword store.
    set_d(1, 1, 2'b01, 32'h203, 32'h1234);
    step(0, w);
    chk("sh_rvalid", 32'(dif.rvalid), 1);
    chk("sh_err", 32'(dif.err), 1);
    chk("sh_rdata", dif.rdata, 0);
    chk("sh_mem3", 32'(dev[32'h203]), 32'(ref_mem[32'h203]));
    chk("sh_mem4", 32'(dev[32'h204]), 32'(ref_mem[32'h204]));
    set_d(0, 0, 2'b00, 0, 0);

    // Illegal size from the core.
    set_c(1, 0, 2'b10, 32'h0, 0);
    step(0, w);
    chk("sz10_err", 32'(cif.err), 1);
    set_c(0, 0, 2'b00, 0, 0);

    // Reset right after a granted load.
    set_c(1, 0, 2'b00, 32'h101, 0);
    step(0, w);
    set_c(0, 0, 2'b00, 0, 0);
    step(1, w);
    step(0, w);
    chk("rst_drop", 32'(cif.rvalid), 0);

    // Alternating solo requesters.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        set_c(1, 0, 2'b11, 32'h100, 0);
        set_d(0, 0, 2'b00, 0, 0);
      end else begin
        set_c(0, 0, 2'b00, 0, 0);
        set_d(1, 1, 2'b00, 32'(i), 32'(i));
      end
      step(0, w);
      chk("alt_c_rv", 32'(cif.rvalid), 32'(i % 2 == 0));
      chk("alt_d_rv", 32'(dif.rvalid), 32'(i % 2 == 1));
    end

    // Random traffic with requests held until granted.
    rand_c();
    rand_d();
    for (int i = 0; i < 400; i++) begin
      bit r;
      r = ($urandom % 40) == 0;
      step(r, w);
      if (w == 1 || !cif.req) rand_c();
      if (w == 2 || !dif.req) rand_d();
    end
    set_c(0, 0, 2'b00, 0, 0);
    set_d(0, 0, 2'b00, 0, 0);
    step(0, w);
    step(0, w);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
